// File: rtl/eeg_wram_rdgen_if.sv
// Bus bundle for eeg_wram_rdgen: config, per-bank WRAM address/data channels and joined output.
// EEG_WRAM_RDGEN_STRIDE_EN adds the CFG_ADD_STR config field.
interface eeg_wram_rdgen_if #(
  parameter int unsigned WRAM_NUM_DW = 4,
  parameter int unsigned WRAM_ADD_AW = 13,
  parameter int unsigned WRAM_DAT_DW = 8
);
  logic                               CFG_INFO_VLD;
  logic                               CFG_INFO_RDY;
  logic [WRAM_ADD_AW-1:0]             CFG_ADD_BAS;
  logic [WRAM_ADD_AW-1:0]             CFG_ADD_LEN;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
  logic [WRAM_ADD_AW-1:0]             CFG_ADD_STR;
`endif
  logic [WRAM_NUM_DW-1:0]             CFG_BNK_MSK;
  logic                               IS_IDLE;
  logic                               RD_DONE;
  logic [WRAM_NUM_DW-1:0]             ETOW_ADD_VLD;
  logic [WRAM_NUM_DW-1:0]             ETOW_ADD_LST;
  logic [WRAM_NUM_DW-1:0]             ETOW_ADD_RDY;
  logic [WRAM_NUM_DW*WRAM_ADD_AW-1:0] ETOW_ADD_ADD;
  logic [WRAM_NUM_DW-1:0]             WTOE_DAT_VLD;
  logic [WRAM_NUM_DW-1:0]             WTOE_DAT_LST;
  logic [WRAM_NUM_DW-1:0]             WTOE_DAT_RDY;
  logic [WRAM_NUM_DW*WRAM_DAT_DW-1:0] WTOE_DAT_DAT;
  logic                               OUT_DAT_VLD;
  logic                               OUT_DAT_LST;
  logic                               OUT_DAT_RDY;
  logic [WRAM_NUM_DW*WRAM_DAT_DW-1:0] OUT_DAT_DAT;

  // Read-generator side.
  modport slave (
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
    input  CFG_ADD_STR,
`endif
    input  CFG_INFO_VLD, CFG_ADD_BAS, CFG_ADD_LEN, CFG_BNK_MSK,
    output CFG_INFO_RDY, IS_IDLE, RD_DONE,
    output ETOW_ADD_VLD, ETOW_ADD_LST, ETOW_ADD_ADD,
    input  ETOW_ADD_RDY,
    input  WTOE_DAT_VLD, WTOE_DAT_LST, WTOE_DAT_DAT,
    output WTOE_DAT_RDY,
    output OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT,
    input  OUT_DAT_RDY
  );

  // Controller / WRAM / consumer side.
  modport master (
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
    output CFG_ADD_STR,
`endif
    output CFG_INFO_VLD, CFG_ADD_BAS, CFG_ADD_LEN, CFG_BNK_MSK,
    input  CFG_INFO_RDY, IS_IDLE, RD_DONE,
    input  ETOW_ADD_VLD, ETOW_ADD_LST, ETOW_ADD_ADD,
    output ETOW_ADD_RDY,
    output WTOE_DAT_VLD, WTOE_DAT_LST, WTOE_DAT_DAT,
    input  WTOE_DAT_RDY,
    input  OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT,
    output OUT_DAT_RDY
  );
endinterface

// File: rtl/eeg_wram_rdgen.sv
// Multi-bank WRAM read generator: independent per-bank address issue, lock-step data join.
// Optional EEG_WRAM_RDGEN_STRIDE_EN adds a configurable address stride (default stride 1).
module eeg_wram_rdgen #(
  parameter int unsigned WRAM_NUM_DW = 4,
  parameter int unsigned WRAM_ADD_AW = 13,
  parameter int unsigned WRAM_DAT_DW = 8
) (
  input logic              clk,
  input logic              rst,
  eeg_wram_rdgen_if.slave  bus
);
  localparam int unsigned NUM = WRAM_NUM_DW;
  localparam int unsigned AW  = WRAM_ADD_AW;
  localparam int unsigned DW  = WRAM_DAT_DW;

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StRun   = 3'b010,
    StDrain = 3'b100
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          len_q, len_d;
  logic [NUM-1:0]         msk_q, msk_d;
  logic [NUM-1:0][AW-1:0] addr_q, addr_d;
  logic [NUM-1:0][AW-1:0] k_q, k_d;
  logic [NUM-1:0]         iss_done_q, iss_done_d;
  logic [AW-1:0]          w_q, w_d;
  logic                   out_done_q, out_done_d;
  logic                   rd_done_q, rd_done_d;
  logic [AW-1:0]          stride;

`ifdef EEG_WRAM_RDGEN_STRIDE_EN
  logic [AW-1:0]          str_q, str_d;
  assign stride = str_q;
`else
  assign stride = AW'(1);
`endif

  logic           is_idle, busy, cfg_hs;
  logic [NUM-1:0] add_vld, add_lst, add_hs, add_last_hs, lane_ok;
  logic           all_issued, out_vld, out_hs, out_last_hs, out_complete;
  logic [NUM*DW-1:0] out_dat;
  logic           unused_lst;

  assign unused_lst = ^bus.WTOE_DAT_LST;

  assign is_idle = (state_q == StIdle);
  assign busy    = (state_q == StRun) || (state_q == StDrain);
  assign cfg_hs  = bus.CFG_INFO_VLD & is_idle;

  always_comb begin
    add_vld = '0;
    add_lst = '0;
    for (int i = 0; i < NUM; i++) begin
      add_vld[i] = (state_q == StRun) & msk_q[i] & ~iss_done_q[i];
      add_lst[i] = add_vld[i] & (k_q[i] == len_q);
    end
  end

  assign add_hs      = add_vld & bus.ETOW_ADD_RDY;
  assign add_last_hs = add_hs & add_lst;
  // Banks finishing their last address this cycle count as done.
  assign all_issued  = &(iss_done_q | ~msk_q | add_last_hs);

  // Disabled lanes never hold up the join.
  assign lane_ok      = bus.WTOE_DAT_VLD | ~msk_q;
  assign out_vld      = busy & (&lane_ok) & ~out_done_q;
  assign out_hs       = out_vld & bus.OUT_DAT_RDY;
  assign out_last_hs  = out_hs & (w_q == len_q);
  assign out_complete = out_done_q | out_last_hs;

  always_comb begin
    out_dat = '0;
    for (int i = 0; i < NUM; i++) begin
      out_dat[i*DW +: DW] = msk_q[i] ? bus.WTOE_DAT_DAT[i*DW +: DW] : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    msk_d      = msk_q;
    addr_d     = addr_q;
    k_d        = k_q;
    iss_done_d = iss_done_q;
    w_d        = w_q;
    out_done_d = out_done_q;
    rd_done_d  = 1'b0;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
    str_d      = str_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cfg_hs) begin
          len_d      = bus.CFG_ADD_LEN;
          msk_d      = bus.CFG_BNK_MSK;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
          str_d      = bus.CFG_ADD_STR;
`endif
          for (int i = 0; i < NUM; i++) addr_d[i] = bus.CFG_ADD_BAS;
          k_d        = '0;
          iss_done_d = '0;
          w_d        = '0;
          out_done_d = 1'b0;
          // An empty bank mask completes immediately without leaving idle.
          if (bus.CFG_BNK_MSK == '0) rd_done_d = 1'b1;
          else                       state_d   = StRun;
        end
      end
      StRun, StDrain: begin
        for (int i = 0; i < NUM; i++) begin
          if (add_hs[i]) begin
            if (add_lst[i]) begin
              iss_done_d[i] = 1'b1;
            end else begin
              k_d[i]    = k_q[i] + AW'(1);
              addr_d[i] = addr_q[i] + stride;
            end
          end
        end
        if (out_hs) begin
          if (w_q == len_q) out_done_d = 1'b1;
          else              w_d        = w_q + AW'(1);
        end
        if (all_issued && out_complete) begin
          state_d   = StIdle;
          rd_done_d = 1'b1;
        end else if (state_q == StRun && all_issued) begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      msk_q      <= '0;
      addr_q     <= '0;
      k_q        <= '0;
      iss_done_q <= '0;
      w_q        <= '0;
      out_done_q <= 1'b0;
      rd_done_q  <= 1'b0;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
      str_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      msk_q      <= msk_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      iss_done_q <= iss_done_d;
      w_q        <= w_d;
      out_done_q <= out_done_d;
      rd_done_q  <= rd_done_d;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
      str_q      <= str_d;
`endif
    end
  end

  assign bus.CFG_INFO_RDY = is_idle;
  assign bus.IS_IDLE      = is_idle;
  assign bus.RD_DONE      = rd_done_q;
  assign bus.ETOW_ADD_VLD = add_vld;
  assign bus.ETOW_ADD_LST = add_lst;
  assign bus.ETOW_ADD_ADD = addr_q;
  assign bus.WTOE_DAT_RDY = msk_q & {NUM{out_hs}};
  assign bus.OUT_DAT_VLD  = out_vld;
  assign bus.OUT_DAT_LST  = out_vld & (w_q == len_q);
  assign bus.OUT_DAT_DAT  = out_dat;

endmodule

// File: tb/tb_eeg_wram_rdgen.sv
// Directed testbench for eeg_wram_rdgen: one task per scenario with hand-computed expectations.
module tb_eeg_wram_rdgen;
  localparam int unsigned NUM = 4;
  localparam int unsigned AW  = 13;
  localparam int unsigned DW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eeg_wram_rdgen_if #(.WRAM_NUM_DW(NUM), .WRAM_ADD_AW(AW), .WRAM_DAT_DW(DW)) bus ();

  eeg_wram_rdgen #(
    .WRAM_NUM_DW(NUM),
    .WRAM_ADD_AW(AW),
    .WRAM_DAT_DW(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] lane_addr(input int i);
    return bus.ETOW_ADD_ADD[i*AW +: AW];
  endfunction

  // Lane i of word w carries 16*w+i+1; masked-off lanes read as zero.
  function automatic logic [NUM*DW-1:0] mk_word(input int w, input logic [NUM-1:0] m);
    logic [NUM*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++) if (m[i]) v[i*DW +: DW] = DW'(16 * w + i + 1);
    return v;
  endfunction

  task automatic start_cfg(input logic [AW-1:0] bas, input logic [AW-1:0] len,
                           input logic [NUM-1:0] msk);
    bus.CFG_ADD_BAS  = bas;
    bus.CFG_ADD_LEN  = len;
    bus.CFG_BNK_MSK  = msk;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
    bus.CFG_ADD_STR  = AW'(1);
`endif
    bus.CFG_INFO_VLD = 1'b1;
    #1;
    vectors++;
    if (bus.CFG_INFO_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_rdy: got %b want 1", bus.CFG_INFO_RDY);
    end
    tick();
    bus.CFG_INFO_VLD = 1'b0;
  endtask

  task automatic drain_words(input int n);
    bus.WTOE_DAT_VLD = '1;
    bus.OUT_DAT_RDY  = 1'b1;
    repeat (n) tick();
    bus.WTOE_DAT_VLD = '0;
  endtask

  task automatic check_done(input string name);
    vectors++;
    if (bus.RD_DONE !== 1'b1 || bus.IS_IDLE !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: got done=%b idle=%b want 1 1", name, bus.RD_DONE, bus.IS_IDLE);
    end
    tick();
    vectors++;
    if (bus.RD_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_pulse: got %b want 0", name, bus.RD_DONE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.WTOE_DAT_VLD = '1;
    bus.WTOE_DAT_DAT = mk_word(3, '1);
    bus.ETOW_ADD_RDY = '1;
    bus.OUT_DAT_RDY  = 1'b1;
    repeat (2) tick();
    vectors++;
    if (bus.IS_IDLE !== 1'b1 || bus.CFG_INFO_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle: got idle=%b rdy=%b want 1 1", bus.IS_IDLE, bus.CFG_INFO_RDY);
    end
    vectors++;
    if ({bus.ETOW_ADD_VLD, bus.ETOW_ADD_LST, bus.WTOE_DAT_RDY} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_vld: got %b %b %b want 0", bus.ETOW_ADD_VLD, bus.ETOW_ADD_LST,
               bus.WTOE_DAT_RDY);
    end
    vectors++;
    if ({bus.OUT_DAT_VLD, bus.OUT_DAT_LST, bus.RD_DONE} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_out: got %b%b%b want 000", bus.OUT_DAT_VLD, bus.OUT_DAT_LST,
               bus.RD_DONE);
    end
    vectors++;
    if (bus.ETOW_ADD_ADD !== '0 || bus.OUT_DAT_DAT !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got add=%h dat=%h want 0 0", bus.ETOW_ADD_ADD, bus.OUT_DAT_DAT);
    end
    rst = 1'b0;
    bus.WTOE_DAT_VLD = '0;
    tick();
  endtask

  task automatic test_basic();
    logic [NUM-1:0] exp_lst;
    bus.ETOW_ADD_RDY = '1;
    bus.OUT_DAT_RDY  = 1'b1;
    bus.WTOE_DAT_VLD = '0;
    start_cfg(13'h10, 13'd3, 4'hF);
    for (int k = 0; k < 4; k++) begin
      exp_lst = (k == 3) ? 4'hF : 4'h0;
      vectors++;
      if (bus.ETOW_ADD_VLD !== 4'hF || bus.ETOW_ADD_LST !== exp_lst) begin
        miscompares++;
        $display("FAIL basic_add_vld k=%0d: got vld=%b lst=%b want 1111 %b", k,
                 bus.ETOW_ADD_VLD, bus.ETOW_ADD_LST, exp_lst);
      end
      for (int i = 0; i < NUM; i++) begin
        vectors++;
        if (lane_addr(i) !== AW'(16 + k)) begin
          miscompares++;
          $display("FAIL basic_addr lane%0d k=%0d: got %h want %h", i, k, lane_addr(i),
                   AW'(16 + k));
        end
      end
      tick();
    end
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'h0 || bus.OUT_DAT_VLD !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: got vld=%b out=%b want 0000 0", bus.ETOW_ADD_VLD,
               bus.OUT_DAT_VLD);
    end
    for (int w = 0; w < 4; w++) begin
      bus.WTOE_DAT_VLD = '1;
      bus.WTOE_DAT_DAT = mk_word(w, '1);
      #1;
      vectors++;
      if (bus.OUT_DAT_VLD !== 1'b1 || bus.OUT_DAT_LST !== (w == 3) ||
          bus.WTOE_DAT_RDY !== 4'hF) begin
        miscompares++;
        $display("FAIL basic_out w=%0d: got vld=%b lst=%b rdy=%b want 1 %0d 1111", w,
                 bus.OUT_DAT_VLD, bus.OUT_DAT_LST, bus.WTOE_DAT_RDY, (w == 3));
      end
      vectors++;
      if (bus.OUT_DAT_DAT !== mk_word(w, 4'hF)) begin
        miscompares++;
        $display("FAIL basic_dat w=%0d: got %h want %h", w, bus.OUT_DAT_DAT, mk_word(w, 4'hF));
      end
      tick();
    end
    bus.WTOE_DAT_VLD = '0;
    check_done("basic");
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    bus.ETOW_ADD_RDY = '1;
    start_cfg(13'h1FFE, 13'd3, 4'hF);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NUM; i++) begin
        vectors++;
        if (lane_addr(i) !== exp_a[k]) begin
          miscompares++;
          $display("FAIL wrap_addr lane%0d k=%0d: got %h want %h", i, k, lane_addr(i), exp_a[k]);
        end
      end
      tick();
    end
    drain_words(4);
    check_done("wrap");
  endtask

  task automatic test_indep();
    logic [AW-1:0] exp_a [4] = '{13'h101, 13'h100, 13'h101, 13'h100};
    bus.ETOW_ADD_RDY = 4'b0101;
    start_cfg(13'h100, 13'd1, 4'hF);
    tick();
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'hF || bus.ETOW_ADD_LST !== 4'b0101) begin
      miscompares++;
      $display("FAIL indep_vld1: got vld=%b lst=%b want 1111 0101", bus.ETOW_ADD_VLD,
               bus.ETOW_ADD_LST);
    end
    for (int i = 0; i < NUM; i++) begin
      vectors++;
      if (lane_addr(i) !== exp_a[i]) begin
        miscompares++;
        $display("FAIL indep_addr lane%0d: got %h want %h", i, lane_addr(i), exp_a[i]);
      end
    end
    tick();
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'b1010 || bus.ETOW_ADD_LST !== 4'b0000) begin
      miscompares++;
      $display("FAIL indep_vld2: got vld=%b lst=%b want 1010 0000", bus.ETOW_ADD_VLD,
               bus.ETOW_ADD_LST);
    end
    bus.ETOW_ADD_RDY = '1;
    tick();
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'b1010 || bus.ETOW_ADD_LST !== 4'b1010 ||
        lane_addr(1) !== 13'h101) begin
      miscompares++;
      $display("FAIL indep_vld3: got vld=%b lst=%b a1=%h want 1010 1010 101", bus.ETOW_ADD_VLD,
               bus.ETOW_ADD_LST, lane_addr(1));
    end
    tick();
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'h0 || bus.IS_IDLE !== 1'b0) begin
      miscompares++;
      $display("FAIL indep_drain: got vld=%b idle=%b want 0000 0", bus.ETOW_ADD_VLD, bus.IS_IDLE);
    end
    drain_words(2);
    check_done("indep");
  endtask

  task automatic test_mask();
    bus.ETOW_ADD_RDY = '1;
    bus.OUT_DAT_RDY  = 1'b1;
    start_cfg(13'h20, 13'd1, 4'b0101);
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'b0101) begin
      miscompares++;
      $display("FAIL mask_add_vld: got %b want 0101", bus.ETOW_ADD_VLD);
    end
    repeat (2) tick();
    for (int w = 0; w < 2; w++) begin
      bus.WTOE_DAT_DAT = mk_word(w, '1);
      bus.WTOE_DAT_VLD = 4'b0001;
      repeat (3) begin
        #1;
        vectors++;
        if (bus.OUT_DAT_VLD !== 1'b0 || bus.WTOE_DAT_RDY !== 4'b0000) begin
          miscompares++;
          $display("FAIL mask_wait w=%0d: got vld=%b rdy=%b want 0 0000", w, bus.OUT_DAT_VLD,
                   bus.WTOE_DAT_RDY);
        end
        tick();
      end
      bus.WTOE_DAT_VLD = 4'b0101;
      #1;
      vectors++;
      if (bus.OUT_DAT_VLD !== 1'b1 || bus.WTOE_DAT_RDY !== 4'b0101 ||
          bus.OUT_DAT_LST !== (w == 1)) begin
        miscompares++;
        $display("FAIL mask_join w=%0d: got vld=%b rdy=%b lst=%b want 1 0101 %0d", w,
                 bus.OUT_DAT_VLD, bus.WTOE_DAT_RDY, bus.OUT_DAT_LST, (w == 1));
      end
      vectors++;
      if (bus.OUT_DAT_DAT !== mk_word(w, 4'b0101)) begin
        miscompares++;
        $display("FAIL mask_dat w=%0d: got %h want %h", w, bus.OUT_DAT_DAT,
                 mk_word(w, 4'b0101));
      end
      tick();
    end
    bus.WTOE_DAT_VLD = '0;
    check_done("mask");
  endtask

  task automatic test_stall();
    bus.ETOW_ADD_RDY = '1;
    start_cfg(13'h40, 13'd3, 4'hF);
    repeat (4) tick();
    bus.WTOE_DAT_VLD = '1;
    bus.WTOE_DAT_DAT = mk_word(0, '1);
    bus.OUT_DAT_RDY  = 1'b1;
    tick();
    bus.WTOE_DAT_DAT = mk_word(1, '1);
    bus.OUT_DAT_RDY  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if (bus.WTOE_DAT_RDY !== 4'h0 || bus.OUT_DAT_VLD !== 1'b1 ||
          bus.OUT_DAT_DAT !== mk_word(1, 4'hF)) begin
        miscompares++;
        $display("FAIL stall c=%0d: got rdy=%b vld=%b dat=%h want 0000 1 %h", c,
                 bus.WTOE_DAT_RDY, bus.OUT_DAT_VLD, bus.OUT_DAT_DAT, mk_word(1, 4'hF));
      end
      tick();
    end
    bus.OUT_DAT_RDY = 1'b1;
    for (int w = 1; w < 4; w++) begin
      bus.WTOE_DAT_DAT = mk_word(w, '1);
      #1;
      vectors++;
      if (bus.OUT_DAT_DAT !== mk_word(w, 4'hF) || bus.OUT_DAT_LST !== (w == 3) ||
          bus.WTOE_DAT_RDY !== 4'hF) begin
        miscompares++;
        $display("FAIL stall_resume w=%0d: got dat=%h lst=%b rdy=%b want %h %0d 1111", w,
                 bus.OUT_DAT_DAT, bus.OUT_DAT_LST, bus.WTOE_DAT_RDY, mk_word(w, 4'hF), (w == 3));
      end
      tick();
    end
    bus.WTOE_DAT_VLD = '0;
    check_done("stall");
  endtask

  task automatic test_zero_mask_busy();
    start_cfg(13'h55, 13'd2, 4'b0000);
    check_done("zero_mask");
    bus.ETOW_ADD_RDY = '0;
    start_cfg(13'h30, 13'd1, 4'hF);
    bus.CFG_ADD_BAS  = 13'h77;
    bus.CFG_INFO_VLD = 1'b1;
    #1;
    vectors++;
    if (bus.CFG_INFO_RDY !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_rdy: got %b want 0", bus.CFG_INFO_RDY);
    end
    tick();
    bus.CFG_INFO_VLD = 1'b0;
    vectors++;
    if (lane_addr(0) !== 13'h30 || bus.IS_IDLE !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_keep: got addr=%h idle=%b want 0030 0", lane_addr(0), bus.IS_IDLE);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_abort();
    bus.ETOW_ADD_RDY = '1;
    start_cfg(13'h80, 13'd7, 4'hF);
    repeat (2) tick();
    vectors++;
    if (lane_addr(0) !== 13'h82 || bus.ETOW_ADD_VLD !== 4'hF) begin
      miscompares++;
      $display("FAIL abort_pre: got addr=%h vld=%b want 0082 1111", lane_addr(0),
               bus.ETOW_ADD_VLD);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.WTOE_DAT_VLD = '1;
    bus.OUT_DAT_RDY  = 1'b1;
    #1;
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'h0 || bus.IS_IDLE !== 1'b1 || bus.OUT_DAT_VLD !== 1'b0 ||
        bus.WTOE_DAT_RDY !== 4'h0) begin
      miscompares++;
      $display("FAIL abort_post: got vld=%b idle=%b out=%b rdy=%b want 0000 1 0 0000",
               bus.ETOW_ADD_VLD, bus.IS_IDLE, bus.OUT_DAT_VLD, bus.WTOE_DAT_RDY);
    end
    bus.WTOE_DAT_VLD = '0;
    start_cfg(13'h5, 13'd0, 4'b0011);
    vectors++;
    if (bus.ETOW_ADD_VLD !== 4'b0011 || bus.ETOW_ADD_LST !== 4'b0011 ||
        lane_addr(1) !== 13'h5) begin
      miscompares++;
      $display("FAIL abort_new_add: got vld=%b lst=%b a1=%h want 0011 0011 0005",
               bus.ETOW_ADD_VLD, bus.ETOW_ADD_LST, lane_addr(1));
    end
    tick();
    bus.WTOE_DAT_VLD = '1;
    bus.WTOE_DAT_DAT = mk_word(0, '1);
    #1;
    vectors++;
    if (bus.OUT_DAT_LST !== 1'b1 || bus.OUT_DAT_DAT !== mk_word(0, 4'b0011) ||
        bus.WTOE_DAT_RDY !== 4'b0011) begin
      miscompares++;
      $display("FAIL abort_new_out: got lst=%b dat=%h rdy=%b want 1 %h 0011", bus.OUT_DAT_LST,
               bus.OUT_DAT_DAT, bus.WTOE_DAT_RDY, mk_word(0, 4'b0011));
    end
    tick();
    bus.WTOE_DAT_VLD = '0;
    check_done("abort_new");
  endtask

  initial begin
    rst              = 1'b1;
    bus.CFG_INFO_VLD = 1'b0;
    bus.CFG_ADD_BAS  = '0;
    bus.CFG_ADD_LEN  = '0;
    bus.CFG_BNK_MSK  = '0;
`ifdef EEG_WRAM_RDGEN_STRIDE_EN
    bus.CFG_ADD_STR  = AW'(1);
`endif
    bus.ETOW_ADD_RDY = '0;
    bus.WTOE_DAT_VLD = '0;
    bus.WTOE_DAT_LST = '0;
    bus.WTOE_DAT_DAT = '0;
    bus.OUT_DAT_RDY  = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_indep();
    test_mask();
    test_stall();
    test_zero_mask_busy();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/eeg_wram_rdgen.md
EEG_WRAM_RDGEN -- requirements
Module: EEG_WRAM_RDGEN

Interface
REQ-001 Parameter WRAM_NUM_DW, default 4: number of WRAM banks/lanes.
REQ-002 Parameter WRAM_ADD_AW, default 13: bank address width.
REQ-003 Parameter WRAM_DAT_DW, default 8: weight data width per bank.
REQ-004 Ports (name direction width meaning) SHALL be:
- clk  in  1  the only clock.
- rst  in  1  reset: synchronous, active-high.
- CFG_INFO_VLD  in  1  config valid.
- CFG_INFO_RDY  out  1  config ready.
- CFG_ADD_BAS  in  WRAM_ADD_AW  start address.
- CFG_ADD_LEN  in  WRAM_ADD_AW  word count minus 1.
- CFG_BNK_MSK  in  WRAM_NUM_DW  enabled banks.
- IS_IDLE  out  1  FSM in IDLE.
- RD_DONE  out  1  one-cycle completion pulse.
- ETOW_ADD_VLD  out  WRAM_NUM_DW  per-bank read address valid.
- ETOW_ADD_LST  out  WRAM_NUM_DW  per-bank last address.
- ETOW_ADD_RDY  in  WRAM_NUM_DW  per-bank address ready.
- ETOW_ADD_ADD  out  WRAM_NUM_DW x WRAM_ADD_AW  per-bank read address.
- WTOE_DAT_VLD  in  WRAM_NUM_DW  returned data valid.
- WTOE_DAT_LST  in  WRAM_NUM_DW  returned data last.
- WTOE_DAT_RDY  out  WRAM_NUM_DW  returned data ready.
- WTOE_DAT_DAT  in  WRAM_NUM_DW x WRAM_DAT_DW  returned data.
- OUT_DAT_VLD  out  1  joined weight word valid.
- OUT_DAT_LST  out  1  last joined word.
- OUT_DAT_RDY  in  1  downstream ready.
- OUT_DAT_DAT  out  WRAM_NUM_DW x WRAM_DAT_DW  joined weight word.

Function
REQ-005 FSM states SHALL be IDLE, RUN, DRAIN (one-hot); IS_IDLE = (state==IDLE); CFG_INFO_RDY = IS_IDLE.
REQ-006 On CFG_INFO_VLD&CFG_INFO_RDY: latch BAS, LEN, MSK; clear all counters; IDLE->RUN; if MSK==0, stay IDLE and pulse RD_DONE next cycle.
REQ-007 RUN: each enabled bank i SHALL drive ETOW_ADD_VLD[i]=1 with address BAS+k (k = its issue counter, 0..LEN), advancing k only on VLD&RDY; disabled banks hold VLD=0.
REQ-008 ETOW_ADD_LST[i] SHALL be 1 iff k==LEN; after the last-address handshake, bank i deasserts VLD for the rest of the job.
REQ-009 Address arithmetic SHALL be modulo 2^WRAM_ADD_AW (BAS+k wraps to 0).
REQ-010 Banks issue independently; no bank waits for another on the address side.
REQ-011 RUN->DRAIN when every enabled bank has completed its last-address handshake (same-cycle completions count).
REQ-012 Join: OUT_DAT_VLD = (RUN|DRAIN) & AND over i of (WTOE_DAT_VLD[i] | ~MSK[i]); combinational, zero latency.
REQ-013 WTOE_DAT_RDY[i] = MSK[i] & OUT_DAT_VLD & OUT_DAT_RDY; all enabled lanes are consumed in the same cycle, never partially.
REQ-014 OUT_DAT_DAT lane i = WTOE_DAT_DAT[i] if MSK[i], else 0.
REQ-015 An output word counter w (0..LEN) SHALL advance on OUT_DAT_VLD&OUT_DAT_RDY; OUT_DAT_LST = OUT_DAT_VLD & (w==LEN).
REQ-016 The last output handshake (in RUN or DRAIN) SHALL, once REQ-011 is also met (same cycle allowed), move to IDLE and pulse RD_DONE for exactly one cycle the following cycle.
REQ-017 WTOE_DAT_LST is ignored for control; w governs completion.
REQ-018 Reset asserted mid-job SHALL abort immediately with no further address or data handshakes.

Reset
REQ-019 On rst=1 at posedge clk: state=IDLE, all counters and latched config 0; ETOW_ADD_VLD, ETOW_ADD_LST, WTOE_DAT_RDY, OUT_DAT_VLD, OUT_DAT_LST and RD_DONE = 0; ETOW_ADD_ADD and OUT_DAT_DAT = 0; CFG_INFO_RDY = IS_IDLE = 1.

Configuration
REQ-020 Macro EEG_WRAM_RDGEN_STRIDE_EN: when defined, adds input CFG_ADD_STR (WRAM_ADD_AW bits), latched with config; the address becomes BAS+k*STR modulo 2^WRAM_ADD_AW. When undefined, the port does not exist and the stride is 1.

Verification
REQ-021 BAS=0x10, LEN=3, MSK=4'b1111, all ready -> each bank issues 0x10..0x13 with LST on 0x13; 4 output words with LST on the 4th; RD_DONE pulses once.
REQ-022 BAS=0x1FFE, LEN=3 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-023 MSK=4'b0101; bank 2 data lags bank 0 by 3 cycles -> OUT_DAT_VLD only when both are valid; lanes 1 and 3 = 0; WTOE_DAT_RDY[1,3]=0.
REQ-024 OUT_DAT_RDY=0 for 10 cycles mid-job -> no WTOE_DAT_RDY, OUT_DAT_DAT stable, no data loss; resumes with correct ordering.
REQ-025 MSK=0 -> FSM stays IDLE and RD_DONE pulses one cycle; config while busy (RUN) -> CFG_INFO_RDY=0, request not accepted.
REQ-026 rst=1 at address 2 of LEN=7 -> all VLD drop on the next edge; a new config then runs to completion correctly.
